// File: rtl/rv32i_ctrl_exec_mem_pkg.sv
// Shared constants for the RV32I control/execute/memory slice: widths, opcodes,
// ALU operation codes, immediate formats and the func3 -> ALU op mapping.
package rv32i_ctrl_exec_mem_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int DMEM_DEPTH = 256;
    localparam int BYTE_ADDR_W = 10;

    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_op_e;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10
    } imm_fmt_e;

    // sub_en/sra_en are the instruction[30] qualifiers; I-ALU never enables SUB.
    function automatic logic [3:0] func3_to_alu(input logic [2:0] func3,
                                                input logic       sub_en,
                                                input logic       sra_en);
        logic [3:0] op;
        case (func3)
            3'b000:  op = sub_en ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = sra_en ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv32i_ctrl_exec_mem_alu.sv
// Combinational ALU with operand-B select; undefined operation codes yield zero.
module alu
    import rv32i_ctrl_exec_mem_pkg::*;
#(
    parameter int DATA_WIDTH = rv32i_ctrl_exec_mem_pkg::DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] rs1_data,
    input  logic [DATA_WIDTH-1:0] rs2_data,
    input  logic [DATA_WIDTH-1:0] imm,
    input  logic                  alu_src,
    input  logic [3:0]            alu_ctrl,
    output logic [DATA_WIDTH-1:0] alu_result,
    output logic                  zero
);

    logic [DATA_WIDTH-1:0] op_b;
    logic [4:0]            shamt;

    assign op_b  = alu_src ? imm : rs2_data;
    assign shamt = op_b[4:0];

    always_comb begin
        alu_result = '0;
        case (alu_ctrl)
            ALU_ADD:  alu_result = rs1_data + op_b;
            ALU_SUB:  alu_result = rs1_data - op_b;
            ALU_AND:  alu_result = rs1_data & op_b;
            ALU_OR:   alu_result = rs1_data | op_b;
            ALU_XOR:  alu_result = rs1_data ^ op_b;
            ALU_SLL:  alu_result = rs1_data << shamt;
            ALU_SRL:  alu_result = rs1_data >> shamt;
            ALU_SRA:  alu_result = $unsigned($signed(rs1_data) >>> shamt);
            ALU_SLT:  alu_result = {{(DATA_WIDTH-1){1'b0}}, $signed(rs1_data) < $signed(op_b)};
            ALU_SLTU: alu_result = {{(DATA_WIDTH-1){1'b0}}, rs1_data < op_b};
            default:  alu_result = '0;
        endcase
    end

    assign zero = (alu_result == '0);

endmodule

// File: rtl/rv32i_ctrl_exec_mem_bram32.sv
// Word-addressed data memory: one synchronous write port, async datapath and debug reads.
module bram32 #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int ADDR_W     = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata,
    input  logic [ADDR_W-1:0]     debug_addr,
    output logic [DATA_WIDTH-1:0] debug_data
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  unused_byte_bits;

    assign unused_byte_bits = ^{waddr[1:0], raddr[1:0], debug_addr[1:0]};

    // NOTE: the array has no reset; contents survive rst, which only blocks the write.
    always_ff @(posedge clk) begin
        if (!rst && we) begin
            mem[waddr[IDX_W+1:2]] <= wdata;
        end
    end

    assign rdata      = (rd_en && !rst) ? mem[raddr[IDX_W+1:2]] : '0;
    assign debug_data = mem[debug_addr[IDX_W+1:2]];

endmodule

// File: rtl/rv32i_ctrl_exec_mem_control.sv
// Combinational main decoder: opcode/func3/func7 to datapath control signals.
module control
    import rv32i_ctrl_exec_mem_pkg::*;
(
    input  logic        rst,
    input  logic [31:0] instruction,
    output logic        branch,
    output logic        mem_read,
    output logic        mem_2_reg,
    output logic        mem_write,
    output logic        alu_src,
    output logic        reg_write,
    output logic [1:0]  imm_src,
    output logic [3:0]  alu_ctrl
);

    logic [6:0] opcode;
    logic [2:0] func3;
    logic       bit30;
    logic       unused_instr_bits;

    assign opcode = instruction[6:0];
    assign func3  = instruction[14:12];
    assign bit30  = instruction[30];
    assign unused_instr_bits = ^{instruction[31], instruction[29:15], instruction[11:7]};

    // NOTE: every output gets a default before the case so no path infers a latch.
    always_comb begin
        branch    = 1'b0;
        mem_read  = 1'b0;
        mem_2_reg = 1'b0;
        mem_write = 1'b0;
        alu_src   = 1'b0;
        reg_write = 1'b0;
        imm_src   = IMM_I;
        alu_ctrl  = ALU_ADD;
        if (!rst) begin
            case (opcode)
                OP_R_TYPE: begin
                    reg_write = 1'b1;
                    alu_ctrl  = func3_to_alu(func3, bit30, bit30);
                end
                OP_I_ALU: begin
                    reg_write = 1'b1;
                    alu_src   = 1'b1;
                    alu_ctrl  = func3_to_alu(func3, 1'b0, bit30);
                end
                OP_LOAD: begin
                    reg_write = 1'b1;
                    alu_src   = 1'b1;
                    mem_read  = 1'b1;
                    mem_2_reg = 1'b1;
                end
                OP_STORE: begin
                    mem_write = 1'b1;
                    alu_src   = 1'b1;
                    imm_src   = IMM_S;
                end
                OP_BRANCH: begin
                    branch   = 1'b1;
                    imm_src  = IMM_B;
                    alu_ctrl = ALU_SUB;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/rv32i_ctrl_exec_mem.sv
// Single-cycle RV32I slice: decoder, ALU and data memory, plus the memory write-source
// and write-back muxes.
module rv32i_ctrl_exec_mem
    import rv32i_ctrl_exec_mem_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            instruction,
    input  logic [DATA_WIDTH-1:0]  rs1_data,
    input  logic [DATA_WIDTH-1:0]  rs2_data,
    input  logic [DATA_WIDTH-1:0]  imm,
    input  logic                   init_done,
    input  logic [BYTE_ADDR_W-1:0] init_addr,
    input  logic [DATA_WIDTH-1:0]  init_data,
    input  logic                   init_we,
    input  logic [BYTE_ADDR_W-1:0] debug_addr,
    output logic [DATA_WIDTH-1:0]  debug_data,
    output logic                   branch,
    output logic                   mem_read,
    output logic                   mem_2_reg,
    output logic                   mem_write,
    output logic                   alu_src,
    output logic                   reg_write,
    output logic [1:0]             imm_src,
    output logic [3:0]             alu_ctrl,
    output logic [DATA_WIDTH-1:0]  alu_result,
    output logic                   zero,
    output logic [DATA_WIDTH-1:0]  mem_rdata,
    output logic [DATA_WIDTH-1:0]  wb_data
);

    logic                   wr_en;
    logic [BYTE_ADDR_W-1:0] wr_addr;
    logic [DATA_WIDTH-1:0]  wr_data;

    control u_control (
        .rst         (rst),
        .instruction (instruction),
        .branch      (branch),
        .mem_read    (mem_read),
        .mem_2_reg   (mem_2_reg),
        .mem_write   (mem_write),
        .alu_src     (alu_src),
        .reg_write   (reg_write),
        .imm_src     (imm_src),
        .alu_ctrl    (alu_ctrl)
    );

    alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .imm        (imm),
        .alu_src    (alu_src),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .zero       (zero)
    );

    // Preload port owns the memory until init_done; afterwards the datapath does.
    assign wr_en   = init_done ? mem_write : init_we;
    assign wr_addr = init_done ? alu_result[BYTE_ADDR_W-1:0] : init_addr;
    assign wr_data = init_done ? rs2_data : init_data;

    bram32 #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DMEM_DEPTH),
        .ADDR_W     (BYTE_ADDR_W)
    ) u_bram32 (
        .clk        (clk),
        .rst        (rst),
        .we         (wr_en),
        .waddr      (wr_addr),
        .wdata      (wr_data),
        .rd_en      (mem_read),
        .raddr      (alu_result[BYTE_ADDR_W-1:0]),
        .rdata      (mem_rdata),
        .debug_addr (debug_addr),
        .debug_data (debug_data)
    );

    assign wb_data = mem_2_reg ? mem_rdata : alu_result;

endmodule

// File: tb/tb_rv32i_ctrl_exec_mem.sv
// Directed self-checking bench for rv32i_ctrl_exec_mem with hand-computed expectations.
module tb_rv32i_ctrl_exec_mem;

    logic        clk;
    logic        rst;
    logic [31:0] instruction;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic        init_done;
    logic [9:0]  init_addr;
    logic [31:0] init_data;
    logic        init_we;
    logic [9:0]  debug_addr;
    logic [31:0] debug_data;
    logic        branch, mem_read, mem_2_reg, mem_write, alu_src, reg_write;
    logic [1:0]  imm_src;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        zero;
    logic [31:0] mem_rdata;
    logic [31:0] wb_data;

    int checks;
    int failures;

    // {branch, mem_read, mem_2_reg, mem_write, alu_src, reg_write, imm_src, alu_ctrl}
    logic [11:0] ctrl_vec;
    assign ctrl_vec = {branch, mem_read, mem_2_reg, mem_write, alu_src, reg_write, imm_src, alu_ctrl};

    rv32i_ctrl_exec_mem dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .imm         (imm),
        .init_done   (init_done),
        .init_addr   (init_addr),
        .init_data   (init_data),
        .init_we     (init_we),
        .debug_addr  (debug_addr),
        .debug_data  (debug_data),
        .branch      (branch),
        .mem_read    (mem_read),
        .mem_2_reg   (mem_2_reg),
        .mem_write   (mem_write),
        .alu_src     (alu_src),
        .reg_write   (reg_write),
        .imm_src     (imm_src),
        .alu_ctrl    (alu_ctrl),
        .alu_result  (alu_result),
        .zero        (zero),
        .mem_rdata   (mem_rdata),
        .wb_data     (wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [31:0] instr, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] im);
        instruction = instr;
        rs1_data    = a;
        rs2_data    = b;
        imm         = im;
        #1;
    endtask

    task automatic preload(input logic [9:0] addr, input logic [31:0] data);
        init_addr = addr;
        init_data = data;
        init_we   = 1'b1;
        tick();
        init_we   = 1'b0;
    endtask

    task automatic peek(input string tag, input logic [9:0] addr, input logic [31:0] expected);
        debug_addr = addr;
        #1;
        check(tag, debug_data, expected);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        instruction = 32'h0;
        rs1_data    = 32'h0;
        rs2_data    = 32'h0;
        imm         = 32'h0;
        init_done   = 1'b0;
        init_addr   = 10'h0;
        init_data   = 32'h0;
        init_we     = 1'b0;
        debug_addr  = 10'h0;
        tick();
        rst = 1'b0;

        // Preload
        preload(10'h000, 32'h0000_0000);
        preload(10'h004, 32'h0000_0014);
        preload(10'h008, 32'hAAAA_5555);
        peek("preload_w1", 10'h004, 32'h0000_0014);
        peek("preload_w2", 10'h008, 32'hAAAA_5555);

        // Reset: load instruction decodes to nothing, memory write blocked
        rst = 1'b1;
        apply(32'h0045_2503, 32'h0, 32'h0, 32'h4);
        check("rst_ctrl", {20'h0, ctrl_vec}, 32'h0);
        check("rst_mem_rdata", mem_rdata, 32'h0);
        init_addr = 10'h008;
        init_data = 32'h1234_5678;
        init_we   = 1'b1;
        tick();
        init_we = 1'b0;
        peek("rst_no_write", 10'h008, 32'hAAAA_5555);
        rst = 1'b0;
        init_done = 1'b1;
        peek("init_done_dbg", 10'h004, 32'h0000_0014);

        // lw x10,4(x10)
        apply(32'h0045_2503, 32'h0, 32'h0, 32'h4);
        check("lw_ctrl", {20'h0, ctrl_vec}, 32'h6C0);
        check("lw_alu", alu_result, 32'h4);
        check("lw_rdata", mem_rdata, 32'h14);
        check("lw_wb", wb_data, 32'h14);

        // sw x11,0(x10): old content visible until the edge
        apply(32'h00B5_2023, 32'h8, 32'hDEAD_BEEF, 32'h0);
        check("sw_ctrl", {20'h0, ctrl_vec}, 32'h190);
        check("sw_rdata", mem_rdata, 32'h0);
        peek("sw_before_edge", 10'h008, 32'hAAAA_5555);
        tick();
        peek("sw_after_edge", 10'h008, 32'hDEAD_BEEF);

        // Store to 0x40C wraps to word 3
        apply(32'h00B5_2023, 32'h40C, 32'h0BAD_F00D, 32'h0);
        tick();
        peek("sw_wrap", 10'h00C, 32'h0BAD_F00D);
        apply(32'h0045_2503, 32'h0, 32'h0, 32'h0);
        // Load: rs1=0x40B + imm=1 = 0x40C, low bits and bit 10 ignored
        apply(32'h0015_2503, 32'h40B, 32'h0, 32'h1);
        check("lw_wrap_alu", alu_result, 32'h40C);
        check("lw_wrap_wb", wb_data, 32'h0BAD_F00D);

        // R-type
        apply(32'h4031_00B3, 32'h5, 32'h7, 32'h0);
        check("sub_ctrl", {20'h0, ctrl_vec}, 32'h041);
        check("sub_res", alu_result, 32'hFFFF_FFFE);
        check("sub_zero", {31'h0, zero}, 32'h0);
        check("sub_wb", wb_data, 32'hFFFF_FFFE);
        apply(32'h0031_20B3, 32'h5, 32'h7, 32'h0);
        check("slt_res", alu_result, 32'h1);
        apply(32'h0031_20B3, 32'hFFFF_FFFF, 32'h1, 32'h0);
        check("slt_neg", alu_result, 32'h1);
        apply(32'h0031_30B3, 32'hFFFF_FFFF, 32'h1, 32'h0);
        check("sltu_big", alu_result, 32'h0);
        apply(32'h4031_50B3, 32'h8000_0000, 32'h4, 32'h0);
        check("sra_ctrl", {20'h0, ctrl_vec}, 32'h047);
        check("sra_res", alu_result, 32'hF800_0000);
        apply(32'h4031_50B3, 32'h8000_0000, 32'h24, 32'h0);
        check("sra_shamt5", alu_result, 32'hF800_0000);
        apply(32'h0031_50B3, 32'h8000_0000, 32'h4, 32'h0);
        check("srl_res", alu_result, 32'h0800_0000);
        apply(32'h0031_10B3, 32'h1, 32'h1F, 32'h0);
        check("sll_res", alu_result, 32'h8000_0000);
        apply(32'h0031_70B3, 32'h0000_F0F0, 32'h0000_FF00, 32'h0);
        check("and_res", alu_result, 32'h0000_F000);
        apply(32'h0031_60B3, 32'h0000_F0F0, 32'h0000_FF00, 32'h0);
        check("or_res", alu_result, 32'h0000_FFF0);
        apply(32'h0031_40B3, 32'h0000_F0F0, 32'h0000_FF00, 32'h0);
        check("xor_res", alu_result, 32'h0000_0FF0);
        apply(32'h0031_00B3, 32'hFFFF_FFFF, 32'h1, 32'h0);
        check("add_wrap", alu_result, 32'h0);
        check("add_zero", {31'h0, zero}, 32'h1);

        // I-ALU: srai uses instr[30]; addi with bit 30 set stays ADD
        apply(32'h4041_5093, 32'h8000_0000, 32'h0, 32'h404);
        check("srai_ctrl", {20'h0, ctrl_vec}, 32'h0C7);
        check("srai_res", alu_result, 32'hF800_0000);
        apply(32'h4001_0093, 32'h1, 32'h7, 32'h400);
        check("addi_ctrl", {20'h0, ctrl_vec}, 32'h0C0);
        check("addi_res", alu_result, 32'h401);

        // beq with equal operands
        apply(32'h0031_0063, 32'h55, 32'h55, 32'h8);
        check("beq_ctrl", {20'h0, ctrl_vec}, 32'h821);
        check("beq_zero", {31'h0, zero}, 32'h1);

        // Unknown opcode
        apply(32'h0000_007F, 32'h5, 32'h7, 32'h0);
        check("unk_ctrl", {20'h0, ctrl_vec}, 32'h0);
        check("unk_rdata", mem_rdata, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv32i_ctrl_exec_mem.md
Name: rv32i_ctrl_exec_mem

Overview:
- Single-cycle RV32I slice containing three units:
  - the main decoder (sub-module control);
  - the ALU (sub-module alu);
  - the word-addressed data memory (sub-module bram32).
- Sits between the register file/sign-extender and the write-back mux of the single-core CPU.
- Provides a preload write port, used while init_done=0, and an asynchronous debug read port.

Parameters:
- DATA_WIDTH, 32, datapath width
- DMEM_DEPTH, 256, data memory words; word index = address[9:2]

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- instruction  in  32  current instruction word
- rs1_data  in  32  register file rs1 value
- rs2_data  in  32  register file rs2 value (second ALU operand and store data)
- imm  in  32  sign-extended immediate
- init_done  in  1  0 = memory write port driven by init_*; 1 = driven by datapath
- init_addr  in  10  preload byte address
- init_data  in  32  preload word
- init_we  in  1  preload write enable
- debug_addr  in  10  debug byte address
- debug_data  out  32  asynchronous read of mem[debug_addr[9:2]]
- branch, mem_read, mem_2_reg, mem_write, alu_src, reg_write  out  1 each  decoder outputs
- imm_src  out  2  immediate format: 00 I, 01 S, 10 B
- alu_ctrl  out  4  ALU operation
- alu_result  out  32  ALU result
- zero  out  1  asserted when alu_result == 0
- mem_rdata  out  32  data memory read data
- wb_data  out  32  mem_2_reg ? mem_rdata : alu_result

Behaviour:
- Decoder is combinational. While rst=1, every decoder output is 0.
- Opcode decode (unlisted fields are 0):
  - 0110011 R-type: reg_write=1; alu_ctrl from func3/func7.
  - 0010011 I-ALU: reg_write=1, alu_src=1, imm_src=00; alu_ctrl from func3. instruction[30] selects SRA only when func3=101; never selects SUB.
  - 0000011 load: reg_write=1, alu_src=1, mem_read=1, mem_2_reg=1, alu_ctrl=ADD. Word access only; func3 is ignored.
  - 0100011 store: mem_write=1, alu_src=1, imm_src=01, alu_ctrl=ADD.
  - 1100011 branch: branch=1, imm_src=10, alu_ctrl=SUB.
  - Any other opcode: all outputs 0.
- alu_ctrl encoding:
  - ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100
  - SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001
  - func3 mapping: 000 ADD/SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND
- ALU is combinational:
  - B = alu_src ? imm : rs2_data.
  - Add/sub wrap modulo 2^32.
  - Shifts use B[4:0].
  - SLT is signed; SLTU is unsigned; result is 0 or 1.
  - Any undefined alu_ctrl yields 0.
- Data memory:
  - Write is synchronous on the rising clk edge. Write source is the init_* port when init_done=0, else address alu_result[9:2], data rs2_data, enable mem_write.
  - Writes are suppressed while rst=1.
  - Read is asynchronous, address alu_result[9:2]. mem_rdata = mem_read ? word : 0. mem_rdata is forced to 0 while rst=1.
  - Read-during-write to the same word returns the old content until the clock edge.
  - Address bits above bit 9 and bits [1:0] are ignored (addresses wrap every 1 KiB).
  - Reset does not clear memory contents.
  - The debug port is always active.
- Latency: all outputs combinational, except memory contents, which update one cycle after a write.

Decomposition:
- Shared package/header rv32i_params.vh: DATA_WIDTH, opcode constants.
- Shared header rv32i_control.vh: ALU_* codes, IMM_* codes.
- Sub-modules: control (decoder), alu, bram32 (memory, with debug port).
- The top level contains only the write-source mux and the wb_data mux.

Test Plan:
- Preload with init_done=0: words 0x00000000, 0x00000014 to addresses 0x0 and 0x4; set init_done=1 -> debug_addr=0x4 gives 0x00000014.
- Self-dependent load: lw x10,4(x10), i.e. instruction 0x00452503, rs1_data=0, imm=4 -> mem_read=1, mem_2_reg=1, reg_write=1, alu_result=4, wb_data=0x00000014.
- Store: sw with rs1_data=8, imm=0, rs2_data=0xDEADBEEF -> after one edge, debug_addr=0x8 gives 0xDEADBEEF; mem_rdata=0 because mem_read=0.
- R-type: sub with rs1_data=5, rs2_data=7 -> alu_result=0xFFFFFFFE, zero=0.
- R-type: slt with the same operands -> 1.
- R-type: sra with rs1_data=0x80000000, rs2_data=4 -> 0xF8000000.
- Branch: beq opcode with equal rs1_data/rs2_data -> branch=1, imm_src=10, zero=1.
- Reset and unknown opcode: rst=1 with a load instruction -> all control outputs 0, mem_rdata=0, no write. Opcode 0x7F -> all control outputs 0.
